// File: rtl/ghost_chase_ctrl.sv
// rtl/ghost_chase_ctrl.sv - ghost steering brain: mode schedule, greedy targeting, stuck recovery
module ghost_chase_ctrl #(
  parameter int unsigned SCATTER_FRAMES = 420,
  parameter int unsigned CHASE_FRAMES   = 1200,
  parameter int unsigned FRIGHT_FRAMES  = 360,
  parameter int unsigned HOLD_FRAMES    = 8,
  parameter logic [9:0]  SCATTER_X      = 10'd396,
  parameter logic [9:0]  SCATTER_Y      = 10'd7
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic       fright_start,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  output logic [7:0] keycode,
  output logic [1:0] mode,
  output logic       frightened
);

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_SCATTER = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_FRIGHT  = 2'd3
  } mode_e;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_UP    = 8'h1A;

  localparam int unsigned MODE_MAX = (CHASE_FRAMES > SCATTER_FRAMES) ? CHASE_FRAMES : SCATTER_FRAMES;
  localparam int MCW = (MODE_MAX > 1) ? $clog2(MODE_MAX) : 1;
  localparam int FCW = (FRIGHT_FRAMES > 1) ? $clog2(FRIGHT_FRAMES) : 1;
  localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [MCW-1:0] SCATTER_LAST = MCW'(SCATTER_FRAMES - 1);
  localparam logic [MCW-1:0] CHASE_LAST   = MCW'(CHASE_FRAMES - 1);
  localparam logic [FCW-1:0] FRIGHT_LAST  = FCW'(FRIGHT_FRAMES - 1);
  localparam logic [HCW-1:0] HOLD_LAST    = HCW'(HOLD_FRAMES - 1);
  // A decision frame counts as the first held frame, so the counter restarts at 1.
  localparam logic [HCW-1:0] HOLD_RESTART = (HOLD_FRAMES > 1) ? HCW'(1) : '0;

  function automatic logic [7:0] reverse_key(input logic [7:0] key);
    case (key)
      KEY_LEFT:  reverse_key = KEY_RIGHT;
      KEY_RIGHT: reverse_key = KEY_LEFT;
      KEY_DOWN:  reverse_key = KEY_UP;
      KEY_UP:    reverse_key = KEY_DOWN;
      default:   reverse_key = KEY_NONE;
    endcase
  endfunction

  function automatic logic [7:0] index_key(input logic [1:0] idx);
    case (idx)
      2'd0:    index_key = KEY_LEFT;
      2'd1:    index_key = KEY_RIGHT;
      2'd2:    index_key = KEY_DOWN;
      default: index_key = KEY_UP;
    endcase
  endfunction

  mode_e            mode_q, mode_d, saved_mode_q, saved_mode_d, sched_next;
  logic [MCW-1:0]   mode_cnt_q, mode_cnt_d;
  logic [FCW-1:0]   fright_cnt_q, fright_cnt_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]       keycode_q, keycode_d;
  logic [3:0]       lfsr_q, lfsr_d;
  logic [9:0]       prev_x_q, prev_y_q;
  logic             seen_same_q, seen_same_d;
  logic             frightened_q, frightened_d;
  logic             mode_change;

  logic [9:0]        tgt_x, tgt_y;
  logic signed [10:0] dx, dy;
  logic [10:0]       adx, ady;
  logic [7:0]        x_key, y_key, primary_key, secondary_key;
  logic [7:0]        greedy_key, stuck_key, rand_pick, random_key;
  logic              same_pos, stuck, decide;

  assign same_pos = (ghostX == prev_x_q) && (ghostY == prev_y_q);
  assign stuck    = seen_same_q && same_pos && (keycode_q != KEY_NONE);

  // Mode schedule: scatter/chase alternation, fright entry/exit and the random source.
  always_comb begin
    mode_d       = mode_q;
    saved_mode_d = saved_mode_q;
    mode_cnt_d   = mode_cnt_q;
    fright_cnt_d = fright_cnt_q;
    sched_next   = mode_q;
    lfsr_d       = lfsr_q;
    if (mode_q == MODE_FRIGHT) begin
      lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end
    if (!enable) begin
      mode_d       = MODE_IDLE;
      saved_mode_d = MODE_SCATTER;
      mode_cnt_d   = '0;
      fright_cnt_d = '0;
    end else begin
      case (mode_q)
        MODE_IDLE: mode_d = MODE_SCATTER;
        MODE_SCATTER, MODE_CHASE: begin
          if (mode_q == MODE_SCATTER) begin
            sched_next = (mode_cnt_q == SCATTER_LAST) ? MODE_CHASE : MODE_SCATTER;
          end else begin
            sched_next = (mode_cnt_q == CHASE_LAST) ? MODE_SCATTER : MODE_CHASE;
          end
          mode_cnt_d = mode_cnt_q + 1'b1;
          if (fright_start) begin
            // Remember where the schedule would have gone, so expiry on this frame is honoured.
            mode_d       = MODE_FRIGHT;
            saved_mode_d = sched_next;
            fright_cnt_d = '0;
          end else begin
            mode_d = sched_next;
          end
        end
        MODE_FRIGHT: begin
          if (fright_start) begin
            fright_cnt_d = '0;
          end else if (fright_cnt_q == FRIGHT_LAST) begin
            mode_d       = saved_mode_q;
            fright_cnt_d = '0;
          end else begin
            fright_cnt_d = fright_cnt_q + 1'b1;
          end
        end
        default: mode_d = MODE_IDLE;
      endcase
      if (mode_d != mode_q) begin
        mode_cnt_d = '0;
      end
    end
    mode_change  = enable && (mode_d != mode_q);
    frightened_d = (mode_d == MODE_FRIGHT);
  end

  // Candidate directions: greedy toward the target, stuck escape, and fright random pick.
  always_comb begin
    tgt_x = (mode_d == MODE_CHASE) ? pacX : SCATTER_X;
    tgt_y = (mode_d == MODE_CHASE) ? pacY : SCATTER_Y;
    dx    = $signed({1'b0, tgt_x}) - $signed({1'b0, ghostX});
    dy    = $signed({1'b0, tgt_y}) - $signed({1'b0, ghostY});
    adx   = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    ady   = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    // A zero delta maps to RIGHT/DOWN, which is the fallback wanted on the secondary axis.
    x_key = dx[10] ? KEY_LEFT : KEY_RIGHT;
    y_key = dy[10] ? KEY_UP : KEY_DOWN;
    if (adx >= ady) begin
      primary_key   = x_key;
      secondary_key = y_key;
    end else begin
      primary_key   = y_key;
      secondary_key = x_key;
    end
    if (dx == '0 && dy == '0) begin
      greedy_key = keycode_q;
    end else if (primary_key == reverse_key(keycode_q)) begin
      greedy_key = secondary_key;
    end else begin
      greedy_key = primary_key;
    end
    stuck_key = (keycode_q == KEY_LEFT || keycode_q == KEY_RIGHT) ? y_key : x_key;
    rand_pick = index_key(lfsr_q[1:0]);
    random_key = (rand_pick == reverse_key(keycode_q)) ? index_key(lfsr_q[1:0] + 2'd1) : rand_pick;
  end

  // Decision timing: mode change beats stuck, stuck beats the hold timer.
  always_comb begin
    keycode_d   = keycode_q;
    hold_cnt_d  = hold_cnt_q;
    seen_same_d = 1'b0;
    decide      = 1'b0;
    if (!enable) begin
      keycode_d  = KEY_NONE;
      hold_cnt_d = '0;
    end else begin
      if (mode_change) begin
        decide    = 1'b1;
        keycode_d = (mode_d == MODE_FRIGHT) ? reverse_key(keycode_q) : greedy_key;
      end else if (stuck) begin
        decide    = 1'b1;
        keycode_d = (mode_q == MODE_FRIGHT) ? random_key : stuck_key;
      end else if (hold_cnt_q == '0) begin
        decide    = 1'b1;
        keycode_d = (mode_q == MODE_FRIGHT) ? random_key : greedy_key;
      end
      if (decide) begin
        hold_cnt_d = HOLD_RESTART;
      end else begin
        hold_cnt_d  = (hold_cnt_q == HOLD_LAST) ? '0 : hold_cnt_q + 1'b1;
        seen_same_d = same_pos && (keycode_q != KEY_NONE);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      mode_q       <= MODE_IDLE;
      saved_mode_q <= MODE_SCATTER;
      mode_cnt_q   <= '0;
      fright_cnt_q <= '0;
      hold_cnt_q   <= '0;
      keycode_q    <= KEY_NONE;
      lfsr_q       <= 4'b1001;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      seen_same_q  <= 1'b0;
      frightened_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      saved_mode_q <= saved_mode_d;
      mode_cnt_q   <= mode_cnt_d;
      fright_cnt_q <= fright_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      keycode_q    <= keycode_d;
      lfsr_q       <= lfsr_d;
      prev_x_q     <= ghostX;
      prev_y_q     <= ghostY;
      seen_same_q  <= seen_same_d;
      frightened_q <= frightened_d;
    end
  end

  assign keycode    = keycode_q;
  assign mode       = mode_q;
  assign frightened = frightened_q;

endmodule

// File: tb/tb_ghost_chase_ctrl.sv
// tb/tb_ghost_chase_ctrl.sv - directed vector bench for ghost_chase_ctrl
module tb_ghost_chase_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       enable;
  logic       fright_start;
  logic [9:0] pacX, pacY, ghostX, ghostY;
  logic [7:0] keycode;
  logic [1:0] mode;
  logic       frightened;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       en;
    logic       fs;
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] gx;
    logic [9:0] gy;
    logic [7:0] key;
    logic [1:0] md;
    logic       fr;
  } vec_t;

  vec_t tbl [13];

  ghost_chase_ctrl #(
    .SCATTER_FRAMES(2),
    .CHASE_FRAMES  (30),
    .FRIGHT_FRAMES (4),
    .HOLD_FRAMES   (4),
    .SCATTER_X     (10'd396),
    .SCATTER_Y     (10'd7)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .enable      (enable),
    .fright_start(fright_start),
    .pacX        (pacX),
    .pacY        (pacY),
    .ghostX      (ghostX),
    .ghostY      (ghostY),
    .keycode     (keycode),
    .mode        (mode),
    .frightened  (frightened)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check_out(input string name, input logic [7:0] ek, input logic [1:0] em, input logic ef);
    n_cmp++;
    if (keycode !== ek) begin
      n_bad++;
      $display("FAIL %s keycode: got %h want %h", name, keycode, ek);
    end
    n_cmp++;
    if (mode !== em) begin
      n_bad++;
      $display("FAIL %s mode: got %0d want %0d", name, mode, em);
    end
    n_cmp++;
    if (frightened !== ef) begin
      n_bad++;
      $display("FAIL %s frightened: got %b want %b", name, frightened, ef);
    end
  endtask

  task automatic step(input string name, input logic en, input logic fs,
                      input logic [9:0] px, input logic [9:0] py,
                      input logic [9:0] gx, input logic [9:0] gy,
                      input logic [7:0] ek, input logic [1:0] em, input logic ef);
    enable       = en;
    fright_start = fs;
    pacX         = px;
    pacY         = py;
    ghostX       = gx;
    ghostY       = gy;
    @(posedge frame_clk);
    #1;
    check_out(name, ek, em, ef);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ghost alternates between two x positions so it never looks stuck
    tbl[0]  = '{1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h07, 2'd1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 10'd200, 10'd60, 10'd51, 10'd50, 8'h07, 2'd1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h07, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 10'd200, 10'd60, 10'd51, 10'd50, 8'h07, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h07, 2'd2, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 10'd200, 10'd60, 10'd51, 10'd50, 8'h07, 2'd2, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h07, 2'd2, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 10'd200, 10'd60, 10'd51, 10'd50, 8'h07, 2'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h07, 2'd2, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 10'd200, 10'd60, 10'd51, 10'd50, 8'h07, 2'd2, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 10'd10,  10'd52, 10'd50, 10'd50, 8'h16, 2'd2, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 10'd10,  10'd52, 10'd50, 10'd50, 8'h16, 2'd2, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 10'd10,  10'd52, 10'd50, 10'd50, 8'h04, 2'd2, 1'b0};

    Reset        = 1'b1;
    enable       = 1'b0;
    fright_start = 1'b0;
    pacX         = '0;
    pacY         = '0;
    ghostX       = '0;
    ghostY       = '0;
    #2;
    check_out("reset", 8'h00, 2'd0, 1'b0);
    repeat (2) @(posedge frame_clk);
    #3;
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), tbl[i].en, tbl[i].fs, tbl[i].px, tbl[i].py,
           tbl[i].gx, tbl[i].gy, tbl[i].key, tbl[i].md, tbl[i].fr);
    end

    // hold timer runs out, then greedy picks UP while moving LEFT
    step("hold1", 1'b1, 1'b0, 10'd52, 10'd10, 10'd51, 10'd50, 8'h04, 2'd2, 1'b0);
    step("hold2", 1'b1, 1'b0, 10'd52, 10'd10, 10'd50, 10'd50, 8'h04, 2'd2, 1'b0);
    step("hold3", 1'b1, 1'b0, 10'd52, 10'd10, 10'd51, 10'd50, 8'h04, 2'd2, 1'b0);
    step("up_dec", 1'b1, 1'b0, 10'd52, 10'd10, 10'd50, 10'd50, 8'h1A, 2'd2, 1'b0);
    // fright entry from CHASE reverses UP to DOWN, then returns to CHASE
    step("fr_in",  1'b1, 1'b1, 10'd200, 10'd60, 10'd51, 10'd50, 8'h16, 2'd3, 1'b1);
    step("fr_1",   1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h16, 2'd3, 1'b1);
    step("fr_2",   1'b1, 1'b0, 10'd200, 10'd60, 10'd51, 10'd50, 8'h16, 2'd3, 1'b1);
    step("fr_3",   1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h16, 2'd3, 1'b1);
    step("fr_out", 1'b1, 1'b0, 10'd200, 10'd60, 10'd51, 10'd50, 8'h07, 2'd2, 1'b0);
    // enable low wins over fright_start
    step("disable", 1'b0, 1'b1, 10'd200, 10'd60, 10'd50, 10'd50, 8'h00, 2'd0, 1'b0);
    step("reenable", 1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h07, 2'd1, 1'b0);
    step("sc_1",    1'b1, 1'b0, 10'd200, 10'd60, 10'd51, 10'd50, 8'h07, 2'd1, 1'b0);
    // fright_start on the scatter expiry frame saves CHASE
    step("exp_fr",  1'b1, 1'b1, 10'd200, 10'd60, 10'd50, 10'd50, 8'h04, 2'd3, 1'b1);
    step("exp_fr1", 1'b1, 1'b0, 10'd200, 10'd60, 10'd51, 10'd50, 8'h04, 2'd3, 1'b1);
    step("exp_fr2", 1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h04, 2'd3, 1'b1);
    step("exp_fr3", 1'b1, 1'b0, 10'd200, 10'd60, 10'd51, 10'd50, 8'h04, 2'd3, 1'b1);
    step("exp_ret", 1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h16, 2'd2, 1'b0);
    step("fr_again", 1'b1, 1'b1, 10'd200, 10'd60, 10'd51, 10'd50, 8'h1A, 2'd3, 1'b1);
    fright_start = 1'b0;
    // asynchronous reset between clock edges while in FRIGHT
    #3;
    Reset = 1'b1;
    #1;
    check_out("async_reset", 8'h00, 2'd0, 1'b0);
    #2;
    Reset = 1'b0;
    step("post_reset", 1'b1, 1'b0, 10'd200, 10'd60, 10'd50, 10'd50, 8'h07, 2'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
